// File: rtl/alu_seq.sv
// Registered execute-stage ALU. Single-cycle ops complete on the accept edge.
// MUL runs an iterative shift-add over WIDTH cycles, and in_ready stays low while it runs.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flags_we,
    input  logic [2:0]       flags_wdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags_out,
    output logic             illegal_op
);

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpAdc = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpAnd = 4'h3;
    localparam logic [3:0] OpNot = 4'h4;
    localparam logic [3:0] OpPsa = 4'h5;
    localparam logic [3:0] OpPsb = 4'h6;
    localparam logic [3:0] OpOr  = 4'h7;
    localparam logic [3:0] OpXor = 4'h8;
    localparam logic [3:0] OpShl = 4'h9;
    localparam logic [3:0] OpShr = 4'hA;
    localparam logic [3:0] OpMul = 4'hB;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic [2:0]         flags_q;
    logic               out_valid_q;
    logic               illegal_q;
    logic [2*WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [2*WIDTH-1:0] mul_acc_q;
    logic [SHW-1:0]     mul_cnt_q;

    logic               accept;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_illegal;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] mul_next;

    assign in_ready   = (state_q == StIdle);
    assign accept     = in_valid & in_ready;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flags_out  = flags_q;
    assign illegal_op = illegal_q;

    assign shamt = operand2[SHW-1:0];

    always_comb begin
        alu_r       = result_q;
        alu_c       = flags_q[0];
        alu_illegal = 1'b0;
        // The bit at index WIDTH (SHL) or index 0 (SHR) is the last bit shifted out.
        shl_ext     = {1'b0, operand1} << shamt;
        shr_ext     = {operand1, 1'b0} >> shamt;
        case (op)
            OpAdd: {alu_c, alu_r} = {1'b0, operand1} + {1'b0, operand2};
            OpAdc: {alu_c, alu_r} = {1'b0, operand1} + {1'b0, operand2}
                                    + {{WIDTH{1'b0}}, flags_q[0]};
            OpSub: begin
                alu_r = operand1 - operand2;
                alu_c = (operand1 < operand2);
            end
            OpAnd: alu_r = operand1 & operand2;
            OpNot: alu_r = ~operand1;
            OpPsa: alu_r = operand1;
            OpPsb: alu_r = operand2;
            OpOr:  alu_r = operand1 | operand2;
            OpXor: alu_r = operand1 ^ operand2;
            OpShl: begin
                alu_r = shl_ext[WIDTH-1:0];
                if (shamt != '0) alu_c = shl_ext[WIDTH];
            end
            OpShr: begin
                alu_r = shr_ext[WIDTH:1];
                if (shamt != '0) alu_c = shr_ext[0];
            end
            OpMul: ;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Accumulator value after the current shift-add step.
    assign mul_next = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= StIdle;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_acc_q   <= '0;
            mul_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            // A completion on the same edge overrides this write below.
            if (flags_we) flags_q <= flags_wdata;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (op == OpMul) begin
                            mul_a_q   <= {{WIDTH{1'b0}}, operand1};
                            mul_b_q   <= operand2;
                            mul_acc_q <= '0;
                            mul_cnt_q <= SHW'(WIDTH - 1);
                            state_q   <= StMul;
                        end else if (alu_illegal) begin
                            out_valid_q <= 1'b1;
                            illegal_q   <= 1'b1;
                        end else begin
                            result_q    <= alu_r;
                            flags_q     <= {alu_r[WIDTH-1], (alu_r == '0), alu_c};
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    mul_acc_q <= mul_next;
                    mul_a_q   <= mul_a_q << 1;
                    mul_b_q   <= mul_b_q >> 1;
                    mul_cnt_q <= mul_cnt_q - 1'b1;
                    if (mul_cnt_q == '0) begin
                        result_q    <= mul_next[WIDTH-1:0];
                        flags_q     <= {mul_next[WIDTH-1], (mul_next[WIDTH-1:0] == '0),
                                        (mul_next[2*WIDTH-1:WIDTH] != '0)};
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16). Stimulus pushes expected completions into a queue.
// A negedge monitor pops an entry and compares it against the DUT on every out_valid pulse.
module tb_alu_seq;

    logic        clk;
    logic        reset_b;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        flags_we;
    logic [2:0]  flags_wdata;
    logic        out_valid;
    logic [15:0] result;
    logic [2:0]  flags_out;
    logic        illegal_op;

    typedef struct packed {
        logic [15:0] r;
        logic [2:0]  f;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu_seq #(.WIDTH(16), .SHW(4)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand1   (operand1),
        .operand2   (operand2),
        .flags_we   (flags_we),
        .flags_wdata(flags_wdata),
        .out_valid  (out_valid),
        .result     (result),
        .flags_out  (flags_out),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any out_valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (reset_b && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", {16'd0, result}, {16'd0, e.r});
                chk("sb_flags", {29'd0, flags_out}, {29'd0, e.f});
                chk("sb_illegal", {31'd0, illegal_op}, {31'd0, e.ill});
            end
        end
    end

    // Called at posedge+1; leaves in_valid low at the next posedge+1.
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input bit push, input logic [15:0] er, input logic [2:0] ef,
                         input logic ei);
        exp_t e;
        in_valid = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        if (push) begin
            e.r   = er;
            e.f   = ef;
            e.ill = ei;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("completion_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        reset_b     = 1'b0;
        in_valid    = 1'b0;
        op          = 4'h0;
        operand1    = '0;
        operand2    = '0;
        flags_we    = 1'b0;
        flags_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, flags_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        // Flags are {N,Z,C}.
        issue(4'h0, 16'hFFFF, 16'h0001, 1, 16'h0000, 3'b011, 1'b0); // ADD
        issue(4'h1, 16'h0001, 16'h0001, 1, 16'h0003, 3'b000, 1'b0); // ADC, Cin=1
        issue(4'h2, 16'h0003, 16'h0005, 1, 16'hFFFE, 3'b101, 1'b0); // SUB borrow
        issue(4'h3, 16'h00F0, 16'h0F00, 1, 16'h0000, 3'b011, 1'b0); // AND keeps C
        issue(4'h9, 16'h8001, 16'h0001, 1, 16'h0002, 3'b001, 1'b0); // SHL 1
        issue(4'hA, 16'h0001, 16'h0000, 1, 16'h0001, 3'b001, 1'b0); // SHR 0, C kept
        issue(4'hA, 16'h8000, 16'h000F, 1, 16'h0001, 3'b000, 1'b0); // SHR 15
        issue(4'h7, 16'h1200, 16'h0034, 1, 16'h1234, 3'b000, 1'b0); // OR
        issue(4'h8, 16'hFFFF, 16'h00FF, 1, 16'hFF00, 3'b100, 1'b0); // XOR
        issue(4'h4, 16'h0000, 16'h1111, 1, 16'hFFFF, 3'b100, 1'b0); // NOT
        issue(4'h5, 16'h8000, 16'h0000, 1, 16'h8000, 3'b100, 1'b0); // PASS A
        issue(4'h6, 16'h8000, 16'h0000, 1, 16'h0000, 3'b010, 1'b0); // PASS B
        wait_done();

        // MUL overflow: busy for 16 cycles, ignored in_valid pulses while busy.
        issue(4'hB, 16'h0100, 16'h0100, 1, 16'h0000, 3'b011, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
            if (i == 3) begin
                in_valid = 1'b1;
                op       = 4'h0;
                operand1 = 16'h1111;
                operand2 = 16'h2222;
            end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_done_ready", {31'd0, in_ready}, 32'd1);
        wait_done();

        issue(4'hB, 16'h0007, 16'h0006, 1, 16'h002A, 3'b000, 1'b0); // MUL 7*6
        operand1 = 16'hFFFF;                                        // ignored after accept
        operand2 = 16'hFFFF;
        wait_done();

        flags_we    = 1'b1;
        flags_wdata = 3'b101;
        @(posedge clk);
        #1;
        flags_we = 1'b0;
        chk("flags_we_only", {29'd0, flags_out}, 32'd5);
        chk("flags_we_no_valid", {31'd0, out_valid}, 32'd0);

        issue(4'hD, 16'h1234, 16'h5678, 1, 16'h002A, 3'b101, 1'b1); // illegal
        wait_done();

        // Reset mid-MUL: no completion must follow.
        issue(4'hB, 16'h0003, 16'h0005, 0, 16'h0000, 3'b000, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_flags", {29'd0, flags_out}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // flags_we on the same edge as an ADD completion: ADD flags win.
        flags_we    = 1'b1;
        flags_wdata = 3'b011;
        issue(4'h0, 16'h7FFF, 16'h0001, 1, 16'h8000, 3'b100, 1'b0);
        flags_we = 1'b0;
        chk("we_vs_add_flags", {29'd0, flags_out}, 32'd4);
        wait_done();
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
